// File: rtl/arf_sched_pkg.sv
// ARF schedule package: slot map, coefficients, schedule ROM, golden model.
// Shared by arf_operand_file and arf_sched_ctrl.
package arf_sched_pkg;

  localparam int ARF_W       = 16;
  localparam int SCHED_DEPTH = 16;
  localparam int COEF_BASE   = 0;
  localparam int IN_BASE     = 16;
  localparam int RES_BASE    = 32;
  localparam int NUM_IN      = 10;
  localparam int OUT27_ADDR  = RES_BASE + 26;
  localparam int OUT28_ADDR  = RES_BASE + 27;

  typedef struct packed {
    logic       mul_en;
    logic [5:0] mul_src_a;
    logic [5:0] mul_src_b;
    logic [5:0] mul_dst;
    logic [4:0] mul_op_id;
    logic       add_en;
    logic [5:0] add_src_a;
    logic [5:0] add_src_b;
    logic [5:0] add_dst;
    logic [4:0] add_op_id;
  } sched_step_t;

  localparam logic [15:0] COEF [16] = '{
    16'd3,  16'd5,  16'd7,  16'd11,
    16'd13, 16'd17, 16'd19, 16'd23,
    16'd29, 16'd31, 16'd37, 16'd41,
    16'd43, 16'd47, 16'd53, 16'd59
  };

  // op k lands in slot RES_BASE+k-1; every source below
  // was produced by an earlier step.
  localparam sched_step_t SCHED_ROM [SCHED_DEPTH] = '{
    '{1'b1, 6'd16, 6'd0,  6'd32, 5'd1,
      1'b0, 6'd0,  6'd0,  6'd0,  5'd0},
    '{1'b1, 6'd17, 6'd1,  6'd33, 5'd2,
      1'b0, 6'd0,  6'd0,  6'd0,  5'd0},
    '{1'b1, 6'd18, 6'd2,  6'd34, 5'd3,
      1'b1, 6'd32, 6'd33, 6'd47, 5'd16},
    '{1'b1, 6'd19, 6'd3,  6'd35, 5'd4,
      1'b1, 6'd32, 6'd34, 6'd48, 5'd17},
    '{1'b1, 6'd47, 6'd4,  6'd36, 5'd5,
      1'b1, 6'd34, 6'd35, 6'd49, 5'd18},
    '{1'b1, 6'd20, 6'd5,  6'd37, 5'd6,
      1'b1, 6'd48, 6'd35, 6'd50, 5'd19},
    '{1'b1, 6'd49, 6'd6,  6'd38, 5'd7,
      1'b1, 6'd36, 6'd37, 6'd51, 5'd20},
    '{1'b1, 6'd21, 6'd7,  6'd39, 5'd8,
      1'b1, 6'd50, 6'd37, 6'd52, 5'd21},
    '{1'b1, 6'd51, 6'd8,  6'd40, 5'd9,
      1'b1, 6'd38, 6'd39, 6'd53, 5'd22},
    '{1'b1, 6'd22, 6'd9,  6'd41, 5'd10,
      1'b0, 6'd0,  6'd0,  6'd0,  5'd0},
    '{1'b1, 6'd53, 6'd10, 6'd42, 5'd11,
      1'b1, 6'd40, 6'd41, 6'd54, 5'd23},
    '{1'b1, 6'd23, 6'd11, 6'd43, 5'd12,
      1'b0, 6'd0,  6'd0,  6'd0,  5'd0},
    '{1'b1, 6'd54, 6'd12, 6'd44, 5'd13,
      1'b1, 6'd42, 6'd43, 6'd55, 5'd24},
    '{1'b1, 6'd24, 6'd13, 6'd45, 5'd14,
      1'b1, 6'd44, 6'd55, 6'd56, 5'd25},
    '{1'b1, 6'd25, 6'd14, 6'd46, 5'd15,
      1'b1, 6'd45, 6'd56, 6'd57, 5'd26},
    '{1'b1, 6'd57, 6'd15, 6'd59, 5'd28,
      1'b1, 6'd46, 6'd52, 6'd58, 5'd27}
  };

  // Straight-line graph evaluation, returns {out_28, out_27}.
  function automatic logic [2*ARF_W-1:0] arf_golden(
    input logic [NUM_IN*ARF_W-1:0] d
  );
    logic [ARF_W-1:0] x [NUM_IN];
    logic [ARF_W-1:0] m1, m2, m3, m4, m5, m6, m7, m8;
    logic [ARF_W-1:0] m9, m10, m11, m12, m13, m14, m15, m28;
    logic [ARF_W-1:0] a16, a17, a18, a19, a20, a21;
    logic [ARF_W-1:0] a22, a23, a24, a25, a26, a27;
    for (int i = 0; i < NUM_IN; i++)
      x[i] = d[i*ARF_W +: ARF_W];
    m1  = x[0] * COEF[0];
    m2  = x[1] * COEF[1];
    m3  = x[2] * COEF[2];
    m4  = x[3] * COEF[3];
    a16 = m1 + m2;
    a17 = m1 + m3;
    a18 = m3 + m4;
    m5  = a16 * COEF[4];
    m6  = x[4] * COEF[5];
    a19 = a17 + m4;
    m7  = a18 * COEF[6];
    a20 = m5 + m6;
    m8  = x[5] * COEF[7];
    a21 = a19 + m6;
    m9  = a20 * COEF[8];
    a22 = m7 + m8;
    m10 = x[6] * COEF[9];
    m11 = a22 * COEF[10];
    a23 = m9 + m10;
    m12 = x[7] * COEF[11];
    m13 = a23 * COEF[12];
    a24 = m11 + m12;
    m14 = x[8] * COEF[13];
    a25 = m13 + a24;
    m15 = x[9] * COEF[14];
    a26 = m14 + a25;
    m28 = a26 * COEF[15];
    a27 = m15 + a21;
    return {m28, a27};
  endfunction

endpackage

// File: rtl/arf_operand_file.sv
// ARF operand file: slots 0-15 read back package coefficients,
// 16-63 are registers cleared by rst_n.
// Ports: ra0..ra3/rd0..rd3 async reads; we0/wa0/wd0 and
// we1/wa1/wd1 sync writes; ld_en/ld_data load the sample set.
module arf_operand_file
  import arf_sched_pkg::*;
#(
  parameter int W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        ra0,
  input  logic [5:0]        ra1,
  input  logic [5:0]        ra2,
  input  logic [5:0]        ra3,
  output logic [W-1:0]      rd0,
  output logic [W-1:0]      rd1,
  output logic [W-1:0]      rd2,
  output logic [W-1:0]      rd3,
  input  logic              we0,
  input  logic [5:0]        wa0,
  input  logic [W-1:0]      wd0,
  input  logic              we1,
  input  logic [5:0]        wa1,
  input  logic [W-1:0]      wd1,
  input  logic              ld_en,
  input  logic [NUM_IN*W-1:0] ld_data
);

  logic [W-1:0] mem [IN_BASE:63];

  function automatic logic [W-1:0] rd(
    input logic [5:0] a
  );
    if (a < 6'(IN_BASE))
      return W'(COEF[a[3:0]]);
    return mem[a];
  endfunction

  assign rd0 = rd(ra0);
  assign rd1 = rd(ra1);
  assign rd2 = rd(ra2);
  assign rd3 = rd(ra3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = IN_BASE; i < 64; i++)
        mem[i] <= '0;
    end else begin
      if (ld_en)
        for (int i = 0; i < NUM_IN; i++)
          mem[IN_BASE+i] <= ld_data[i*W +: W];
      if (we0)
        mem[wa0] <= wd0;
      if (we1)
        mem[wa1] <= wd1;
    end
  end

endmodule

// File: rtl/arf_sched_ctrl.sv
// ARF sequencer: runs the 28-op graph on one shared multiplier and
// one shared adder from a static schedule ROM.
// Ports: in_* sample handshake, out_* result handshake, mul_*/add_*
// shared-unit operands/results, *_approx mode selects, busy.
// Optional: ARF_APPROX_EN enables per-op approximate-mode selects.
module arf_sched_ctrl
  import arf_sched_pkg::*;
#(
  parameter int W         = 16,
  parameter int MUL_LAT   = 2,
  parameter int ADD_LAT   = 1,
  parameter int NUM_STEPS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN*W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_27,
  output logic [W-1:0]      out_28,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [W-1:0]      mul_res,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W-1:0]      add_res,
  output logic              mul_approx,
  output logic              add_approx,
  input  logic [27:0]       approx_mask,
  output logic              busy
);

  localparam int LMAX =
    (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int SW = $clog2(NUM_STEPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [SW-1:0] step, step_nx;
  logic [7:0]    cnt, cnt_nx;
  logic          init;
  logic          accept;
  logic          cap;
  logic          done;
  sched_step_t   cur;

  logic [5:0]   ra0, ra1;
  logic [W-1:0] rd0, rd1, rd2, rd3;

  assign cur  = SCHED_ROM[step];
  assign done = (state == S_DONE);
  assign busy = (state == S_ISSUE) |
                (state == S_WAIT);

  // init keeps in_ready low during the reset cycle.
  assign in_ready = init & ((state == S_IDLE) |
                            (done & out_ready));
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      step  <= '0;
      cnt   <= '0;
      init  <= 1'b0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      cnt   <= cnt_nx;
      init  <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step;
    cnt_nx   = cnt;
    cap      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_ISSUE;
          step_nx  = '0;
          cnt_nx   = '0;
        end
      end
      S_ISSUE: begin
        if (LMAX == 1) begin
          cap = 1'b1;
        end else begin
          state_nx = S_WAIT;
          cnt_nx   = 8'd1;
        end
      end
      S_WAIT: begin
        if (cnt == 8'(LMAX-1))
          cap = 1'b1;
        else
          cnt_nx = cnt + 8'd1;
      end
      S_DONE: begin
        if (out_ready) begin
          state_nx = accept ? S_ISSUE : S_IDLE;
          step_nx  = '0;
          cnt_nx   = '0;
        end
      end
    endcase
    if (cap) begin
      step_nx  = step + 1'b1;
      cnt_nx   = '0;
      state_nx = (step == SW'(NUM_STEPS-1)) ?
                 S_DONE : S_ISSUE;
    end
  end

  // Ports 0/1 serve the multiplier while running and
  // the two result slots in DONE.
  always_comb begin
    ra0 = cur.mul_src_a;
    ra1 = cur.mul_src_b;
    unique case (1'b1)
      done: begin
        ra0 = 6'(OUT27_ADDR);
        ra1 = 6'(OUT28_ADDR);
      end
      default: ;
    endcase
  end

  arf_operand_file #(
    .W(W)
  ) u_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra0     (ra0),
    .ra1     (ra1),
    .ra2     (cur.add_src_a),
    .ra3     (cur.add_src_b),
    .rd0     (rd0),
    .rd1     (rd1),
    .rd2     (rd2),
    .rd3     (rd3),
    .we0     (cap & cur.mul_en),
    .wa0     (cur.mul_dst),
    .wd0     (mul_res),
    .we1     (cap & cur.add_en),
    .wa1     (cur.add_dst),
    .wd1     (add_res),
    .ld_en   (accept),
    .ld_data (in_data)
  );

  assign mul_a = (busy & cur.mul_en) ? rd0 : '0;
  assign mul_b = (busy & cur.mul_en) ? rd1 : '0;
  assign add_a = (busy & cur.add_en) ? rd2 : '0;
  assign add_b = (busy & cur.add_en) ? rd3 : '0;

  assign out_valid = done;
  assign out_27    = done ? rd0 : '0;
  assign out_28    = done ? rd1 : '0;

`ifdef ARF_APPROX_EN
  logic [27:0] mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mask <= '0;
    else if (accept)
      mask <= approx_mask;
  end

  // op_id is 1-based; the enable gates the idle id of 0.
  assign mul_approx = busy & cur.mul_en &
                      mask[cur.mul_op_id - 5'd1];
  assign add_approx = busy & cur.add_en &
                      mask[cur.add_op_id - 5'd1];
`else
  logic [27:0] unused_mask;
  logic [9:0]  unused_ids;

  assign unused_mask = approx_mask;
  assign unused_ids  = {cur.mul_op_id,
                        cur.add_op_id};
  assign mul_approx  = 1'b0;
  assign add_approx  = 1'b0;
`endif

  a_dst_clash: assert property (
    @(posedge clk) disable iff (!rst_n)
    (cap && cur.mul_en && cur.add_en) |->
      (cur.mul_dst != cur.add_dst)
  );

endmodule

// File: tb/tb_arf_sched_ctrl.sv
// Testbench for arf_sched_ctrl with behavioural shared units.
// Checks results against arf_golden and handshake timing rules.
module tb_arf_sched_ctrl;
  import arf_sched_pkg::*;

  localparam int W   = 16;
  localparam int LAT = 33;
  localparam int LM  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [NUM_IN*W-1:0] in_data = '0;
  logic [27:0] approx_mask = '0;
  logic in_ready, out_valid, busy;
  logic mul_approx, add_approx;
  logic [W-1:0] out_27, out_28;
  logic [W-1:0] mul_a, mul_b, add_a, add_b;
  logic [W-1:0] mul_res, add_res;
  logic [W-1:0] mul_q = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mul_act = 0;
  int add_act = 0;
  int mapx = 0;
  int aapx = 0;
  int mfirst = -1;
  logic mprev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier with one register stage, combinational adder.
  always @(posedge clk) mul_q <= mul_a * mul_b;
  assign mul_res = mul_q;
  assign add_res = add_a + add_b;

  always @(negedge clk) begin
    if (mul_a != '0) mul_act <= mul_act + 1;
    if (add_a != '0) add_act <= add_act + 1;
    if (mul_approx) mapx <= mapx + 1;
    if (add_approx) aapx <= aapx + 1;
    if (mul_approx && !mprev) mfirst <= cyc;
    mprev <= mul_approx;
  end

  arf_sched_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_27      (out_27),
    .out_28      (out_28),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_res     (mul_res),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_res     (add_res),
    .mul_approx  (mul_approx),
    .add_approx  (add_approx),
    .approx_mask (approx_mask),
    .busy        (busy)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_IN*W-1:0] rnd_set();
    logic [NUM_IN*W-1:0] d;
    for (int i = 0; i < NUM_IN; i++)
      d[i*W +: W] = W'($urandom);
    return d;
  endfunction

  // Called at a negedge; returns one negedge after accept.
  task automatic start_set(input logic [NUM_IN*W-1:0] d,
                           input logic [27:0] m,
                           input string tag,
                           output int acc);
    in_data = d;
    approx_mask = m;
    in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int acc,
                          input logic [NUM_IN*W-1:0] d,
                          input string tag);
    logic [2*W-1:0] g;
    int n;
    g = arf_golden(d);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(cyc - acc), 64'(LAT));
    check({tag, "_out27"}, 64'(out_27), 64'(g[W-1:0]));
    check({tag, "_out28"}, 64'(out_28), 64'(g[2*W-1:W]));
  endtask

  task automatic release_out(input string tag);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check({tag, "_to_idle"},
          64'({out_valid, in_ready, busy}), 64'(3'b010));
  endtask

  initial begin
    int acc;
    int m0, a0, x0, y0;
    int bad;
    logic [NUM_IN*W-1:0] d;
    logic [W-1:0] h27, h28;

    // Reset state
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_ctl",
          64'({in_ready, out_valid, busy,
               mul_approx, add_approx}), 64'd0);
    check("rst_mul_out",
          {out_27, out_28, mul_a, mul_b}, 64'd0);
    check("rst_add", 64'({add_a, add_b}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_cycle_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("idle_ready", 64'(in_ready), 64'd1);

    // 1: all-zero sample set
    start_set('0, 28'(~0), "t1", acc);
    wait_out(acc, '0, "t1");
    check("t1_zero", {32'd0, out_28, out_27}, 64'd0);
    release_out("t1");

    // 2: slices 1..10, count enabled steps
    for (int i = 0; i < NUM_IN; i++)
      d[i*W +: W] = W'(i + 1);
    m0 = mul_act;
    a0 = add_act;
    start_set(d, 28'($urandom), "t2", acc);
    wait_out(acc, d, "t2");
    check("t2_mul_steps", 64'((mul_act - m0) / LM), 64'd16);
    check("t2_add_steps", 64'((add_act - a0) / LM), 64'd12);
    release_out("t2");

    // 3: back-to-back accept in the DONE cycle
    d = rnd_set();
    start_set(d, 28'($urandom), "t3a", acc);
    wait_out(acc, d, "t3a");
    d = rnd_set();
    out_ready = 1'b1;
    start_set(d, 28'($urandom), "t3b", acc);
    out_ready = 1'b0;
    #1;
    check("t3_no_bubble",
          64'({busy, out_valid}), 64'(2'b10));
    wait_out(acc, d, "t3b");

    // 4: backpressure, new set offered but ignored
    h27 = out_27;
    h28 = out_28;
    in_data = rnd_set();
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_27 !== h27 || out_28 !== h28 ||
          out_valid !== 1'b1 || in_ready !== 1'b0)
        bad++;
    end
    check("t4_hold", 64'(bad), 64'd0);
    check("t4_final27", 64'(out_27), 64'(h27));
    release_out("t4");

    // 5: reset pulse at step 7, then a fresh set
    d = rnd_set();
    start_set(d, 28'($urandom), "t5a", acc);
    repeat (2 * 7 - 1) @(negedge clk);
    check("t5_busy_step7", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctl",
          64'({in_ready, out_valid, busy,
               mul_approx, add_approx}), 64'd0);
    check("t5_rst_data",
          {out_27, out_28, mul_a, mul_b}, 64'd0);
    check("t5_rst_add", 64'({add_a, add_b}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d = rnd_set();
    start_set(d, 28'($urandom), "t5b", acc);
    wait_out(acc, d, "t5b");
    release_out("t5b");

    // Random sets
    for (int r = 0; r < 3; r++) begin
      d = rnd_set();
      start_set(d, 28'($urandom), "rnd", acc);
      wait_out(acc, d, "rnd");
      release_out("rnd");
    end

    // 6: approximate-mode selects
`ifdef ARF_APPROX_EN
    x0 = mapx;
    y0 = aapx;
    d = rnd_set();
    start_set(d, 28'h1, "t6", acc);
    wait_out(acc, d, "t6");
    check("t6_mul_apx_cycles", 64'(mapx - x0), 64'(LM));
    check("t6_mul_apx_first", 64'(mfirst), 64'(acc + 1));
    check("t6_add_apx_cycles", 64'(aapx - y0), 64'd0);
    release_out("t6");
`else
    x0 = 0;
    y0 = 0;
    check("t6_apx_off", 64'(mapx - x0 + aapx - y0), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
